// File: rtl/leaf_stream_packetizer.sv
// Packetizes a 32-bit operator stream into 49-bit BFT packets toward one destination leaf.
// The destination is set by config packets. Flow control uses credits returned by the BFT.
module leaf_stream_packetizer #(
  parameter int INIT_CREDITS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ap_start,
  input  logic [48:0] din_leaf_bft2interface,
  input  logic        resend,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [48:0] dout_leaf_interface2bft,
  output logic        configured,
  output logic [3:0]  credits
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  CRED_MAX = 4'(INIT_CREDITS);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {UNCONF, WAIT_START, RUN} state_t;
  typedef struct packed {
    logic       vld;
    logic [4:0] leaf;
    logic [2:0] port;
    logic [7:0] seq;
    logic [31:0] data;
  } pkt_t;

  state_t      state, state_nxt;
  pkt_t        din_p, dout_q, dout_nxt, last_pkt;
  logic [4:0]  dst_leaf;
  logic [2:0]  dst_port;
  logic [7:0]  seq;
  logic [3:0]  cred_nxt;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, fifo_cnt;
  logic        fifo_full, fifo_empty, push, send, is_cfg, is_cred;

  assign din_p   = din_leaf_bft2interface;
  assign is_cfg  = din_p.vld && (din_p.port == 3'd0);
  assign is_cred = din_p.vld && (din_p.port == 3'd1);

  logic unused_din;
  assign unused_din = ^{din_p.leaf, din_p.seq, din_p.data[31:8]};

  // Ready comes from the registered count only; a same-cycle pop never frees a slot early.
  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign s_tready   = reset_n && !fifo_full;
  assign push       = s_tvalid && s_tready;

  assign dout_leaf_interface2bft = dout_q;
  assign configured              = (state != UNCONF);

  always_comb begin
    state_nxt = state;
    send      = 1'b0;
    dout_nxt  = '0;
    case (state)
      UNCONF:     if (is_cfg)   state_nxt = WAIT_START;
      WAIT_START: if (ap_start) state_nxt = RUN;
      RUN:        send = !fifo_empty && (credits != 4'd0) && !resend;
      default:    state_nxt = UNCONF;
    endcase
    if (send)        dout_nxt = {1'b1, dst_leaf, dst_port, seq, mem[rd_ptr[AW-1:0]]};
    else if (resend) dout_nxt = last_pkt;
  end

  // A return in the same cycle as a send cancels out.
  always_comb begin
    cred_nxt = credits;
    if (is_cred && !send)      cred_nxt = (credits >= CRED_MAX) ? CRED_MAX : credits + 4'd1;
    else if (send && !is_cred) cred_nxt = credits - 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= UNCONF;
      dout_q   <= '0;
      last_pkt <= '0;
      dst_leaf <= '0;
      dst_port <= '0;
      seq      <= '0;
      credits  <= CRED_MAX;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state   <= state_nxt;
      dout_q  <= dout_nxt;
      credits <= cred_nxt;
      if (is_cfg) begin
        dst_leaf <= din_p.data[7:3];
        dst_port <= din_p.data[2:0];
      end
      if (send) begin
        last_pkt <= dout_nxt;
        seq      <= seq + 8'd1;
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
  end
endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Bench for leaf_stream_packetizer: a queue-based packet model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_leaf_stream_packetizer;
  localparam int INIT  = 8;
  localparam int DEPTH = 4;
  localparam logic [48:0] CFG_PKT  = 49'h1_0000_0000_002B;  // leaf 5, port 3
  localparam logic [48:0] CRED_PKT = 49'h1_0100_0000_0000;  // port field = 1

  logic        clk = 0, reset_n = 0, ap_start = 0, resend = 0, s_tvalid = 0;
  logic [48:0] din = '0;
  logic [31:0] s_tdata = '0;
  logic        s_tready, configured;
  logic [48:0] dout;
  logic [3:0]  credits;

  int total = 0, bad = 0, sent = 0;
  bit wrapped = 0;
  logic [7:0] prev_seq = 8'd0;

  leaf_stream_packetizer #(.INIT_CREDITS(INIT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .din_leaf_bft2interface(din), .resend(resend),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .dout_leaf_interface2bft(dout), .configured(configured), .credits(credits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Model: buffered beats in a queue, counters as plain integers.
  logic [31:0] q[$];
  int          m_cred = INIT;
  logic [7:0]  m_seq = 0;
  logic [48:0] m_last = '0, m_dout = '0;
  logic [4:0]  m_leaf = 0;
  logic [2:0]  m_port = 0;
  bit          m_cfg = 0, m_run = 0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      q.delete(); m_cred = INIT; m_seq = 0; m_last = '0; m_dout = '0;
      m_leaf = 0; m_port = 0; m_cfg = 0; m_run = 0;
    end else begin
      bit snd, cfgp, crdp, room;
      logic [48:0] nd;
      logic [31:0] head;
      room = q.size() < DEPTH;
      cfgp = din[48] && din[42:40] == 3'd0;
      crdp = din[48] && din[42:40] == 3'd1;
      snd  = m_run && q.size() != 0 && m_cred > 0 && !resend;
      nd   = '0;
      if (snd) begin
        head = q.pop_front();
        nd = {1'b1, m_leaf, m_port, m_seq, head};
        m_last = nd;
        m_seq = m_seq + 8'd1;
      end else if (resend) nd = m_last;
      m_dout = nd;
      if (crdp && !snd) m_cred = (m_cred < INIT) ? m_cred + 1 : INIT;
      else if (snd && !crdp) m_cred = m_cred - 1;
      if (m_cfg && ap_start) m_run = 1;
      if (cfgp) begin m_leaf = din[7:3]; m_port = din[2:0]; m_cfg = 1; end
      if (room && s_tvalid) q.push_back(s_tdata);
    end
  end

  // Compare process, plus packet counting and seq-wrap detection.
  initial forever begin
    @(negedge clk);
    chk("dout", dout, m_dout);
    chk("credits", credits, 64'(m_cred));
    chk("configured", configured, m_cfg);
    chk("s_tready", s_tready, reset_n && q.size() < DEPTH);
    if (dout[48] && !resend) begin
      sent++;
      if (prev_seq == 8'd255 && dout[39:32] == 8'd0) wrapped = 1;
      prev_seq = dout[39:32];
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    reset_n = 0; ap_start = 0; resend = 0; s_tvalid = 0; din = '0;
    step(2);
    reset_n = 1;
    step(1);
  endtask

  task automatic bring_up();
    din = CFG_PKT; step(1);
    din = '0; ap_start = 1; step(1);
    ap_start = 0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    int i = 0, guard = 0;
    logic acc;
    s_tvalid = 1; s_tdata = base;
    while (i < n && guard < 2000) begin
      acc = s_tready;
      step(1); guard++;
      if (acc) begin i++; s_tdata = base + 32'(i); end
    end
    s_tvalid = 0;
    chk("push_done", 64'(i), 64'(n));
  endtask

  task automatic wait_pkt(input string nm);
    int g = 0;
    while (!dout[48] && g < 20) begin step(1); g++; end
    chk(nm, dout[48], 1'b1);
  endtask

  initial begin
    logic [48:0] pkt4;
    int g;
    // reset values while held in reset
    step(1);
    chk("rst_dout", dout, 49'h0);
    chk("rst_credits", credits, 4'd8);
    chk("rst_configured", configured, 1'b0);
    chk("rst_tready", s_tready, 1'b0);
    reset_n = 1; step(1);

    // beats buffered while unconfigured; ready drops once four are held
    s_tvalid = 1; s_tdata = 32'hA0; step(3);
    chk("unconf_tready3", s_tready, 1'b1);
    step(1);
    chk("unconf_tready4", s_tready, 1'b0);
    step(2);
    s_tvalid = 0;
    chk("unconf_dout", dout, 49'h0);

    // config + start + one beat, two cycles from handshake to dout
    do_reset();
    bring_up();
    chk("cfg_configured", configured, 1'b1);
    s_tvalid = 1; s_tdata = 32'hDEADBEEF; step(1);
    s_tvalid = 0;
    chk("lat_not_yet", dout, 49'h0);
    step(1);
    chk("first_pkt", dout, 49'h1_2B00_DEAD_BEEF);
    chk("first_credits", credits, 4'd7);

    // credit exhaustion, single return, same-cycle return + send
    do_reset();
    bring_up();
    sent = 0;
    push_n(10, 32'h100);
    step(4);
    chk("exhaust_sent", 64'(sent), 64'd8);
    chk("exhaust_credits", credits, 4'd0);
    din = CRED_PKT; step(1);
    din = '0; step(3);
    chk("ret_sent", 64'(sent), 64'd9);
    chk("ret_credits", credits, 4'd0);
    din = CRED_PKT; step(2);
    din = '0;
    chk("same_cycle_credits", credits, 4'd1);
    step(2);
    chk("same_cycle_sent", 64'(sent), 64'd10);

    // resend repeats the seq-4 packet twice; next send carries seq 5
    do_reset();
    bring_up();
    push_n(5, 32'h400);
    g = 0;
    while (!(dout[48] && dout[39:32] == 8'd4) && g < 20) begin step(1); g++; end
    pkt4 = dout;
    chk("pkt4", pkt4, 49'h1_2B04_0000_0404);
    resend = 1; step(1);
    chk("resend1", dout, 49'h1_2B04_0000_0404);
    step(1);
    chk("resend2", dout, 49'h1_2B04_0000_0404);
    resend = 0;
    push_n(1, 32'h555);
    wait_pkt("pkt5_seen");
    chk("pkt5", dout, 49'h1_2B05_0000_0555);

    // seq wraps with credits replenished every cycle
    do_reset();
    bring_up();
    wrapped = 0; sent = 0;
    din = CRED_PKT;
    push_n(260, 32'h0);
    din = '0;
    step(4);
    chk("wrap_sent", 64'(sent), 64'd260);
    chk("wrap_seen", wrapped, 1'b1);

    // async reset mid-stream with buffered beats and low credits
    do_reset();
    bring_up();
    push_n(6, 32'h600);
    step(3);
    chk("pre_rst_credits", credits, 4'd2);
    resend = 1;
    push_n(3, 32'h700);
    chk("pre_rst_dout", dout, 49'h1_2B05_0000_0605);
    #2 reset_n = 0;
    #1;
    chk("async_dout", dout, 49'h0);
    chk("async_credits", credits, 4'd8);
    chk("async_configured", configured, 1'b0);
    chk("async_tready", s_tready, 1'b0);
    step(1);
    reset_n = 1; resend = 0; ap_start = 1; sent = 0;
    step(8);
    ap_start = 0;
    chk("post_rst_sent", 64'(sent), 64'd0);
    chk("post_rst_configured", configured, 1'b0);
    chk("post_rst_tready", s_tready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
